// File: rtl/mc6502_pkg.sv
// mc6502_pkg: shared types and constants for the MC6502 core
package mc6502_pkg;
  typedef enum logic [2:0] {IDLE, PUSH_PCH, PUSH_PCL, PUSH_PSR, VEC_L, VEC_H} il_state_e;
  typedef enum logic [1:0] {SRC_RESET, SRC_NMI, SRC_BRK, SRC_IRQ} il_src_e;
  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ = 16'hFFFE;
  localparam logic [7:0] STACK_PAGE = 8'h01;
  localparam int PSR_B = 4;
  localparam int PSR_U = 5;
  function automatic logic [15:0] vector_of(il_src_e s);
    return s == SRC_NMI ? VEC_NMI : s == SRC_RESET ? VEC_RESET : VEC_IRQ;
  endfunction
endpackage

// File: rtl/mc6502_interrupt_sequencer.sv
// mc6502_interrupt_sequencer: reset/NMI/BRK/IRQ stack push and vector fetch
module mc6502_interrupt_sequencer
  import mc6502_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        irq,
  input  logic        nmi,
  input  logic        mc2il_brk,
  input  logic        mc2il_idle,
  input  logic [15:0] rf2il_pc,
  input  logic [7:0]  rf2il_s,
  input  logic [7:0]  rf2il_psr,
  input  logic        rf2il_i,
  output logic        il2mm_req,
  output logic        il2mm_we,
  output logic [15:0] il2mm_addr,
  output logic [7:0]  il2mm_data,
  input  logic        mm2il_ack,
  input  logic [7:0]  mm2il_data,
  output logic [7:0]  il2rf_data,
  output logic        il2rf_set_pcl,
  output logic        il2rf_set_pch,
  output logic        il2rf_pushed,
  output logic        il2rf_set_i,
  output logic        il2rf_set_b,
  output logic        il2mc_busy
);
  il_state_e state, state_n;
  il_src_e src, src_n, acc_src;
  logic [15:0] pc_q, pc_n, addr_n;
  logic [7:0] psr_q, psr_n, sp, sp_n, wdata_n, rf_data_n, psr_push;
  logic nmi_prev, nmi_pend, nmi_pend_n;
  logic req_n, we_n, pushed_n, set_b_n, set_pcl_n, set_pch_n, busy_n;
  logic done, accept, nmi_edge;
  assign done = il2mm_req & mm2il_ack;
  assign nmi_edge = nmi & ~nmi_prev;
  assign accept = state == IDLE & mc2il_idle & (nmi_pend | mc2il_brk | (irq & ~rf2il_i));
  assign acc_src = nmi_pend ? SRC_NMI : mc2il_brk ? SRC_BRK : SRC_IRQ;
  always_comb begin
    state_n = state;
    src_n = src;
    pc_n = pc_q;
    psr_n = psr_q;
    sp_n = sp;
    req_n = il2mm_req;
    we_n = il2mm_we;
    addr_n = il2mm_addr;
    wdata_n = il2mm_data;
    rf_data_n = il2rf_data;
    pushed_n = 1'b0;
    set_b_n = 1'b0;
    set_pcl_n = 1'b0;
    set_pch_n = 1'b0;
    nmi_pend_n = nmi_edge | (nmi_pend & ~(accept & nmi_pend));
    psr_push = psr_q;
    psr_push[PSR_U] = 1'b1;
    psr_push[PSR_B] = src == SRC_BRK;
    case (state)
      IDLE: if (accept) begin
        state_n = PUSH_PCH;
        src_n = acc_src;
        pc_n = rf2il_pc;
        psr_n = rf2il_psr;
        sp_n = rf2il_s - 8'd1;
        req_n = 1'b1;
        we_n = 1'b1;
        addr_n = {STACK_PAGE, rf2il_s};
        wdata_n = rf2il_pc[15:8];
      end
      PUSH_PCH: if (done) begin
        state_n = PUSH_PCL;
        sp_n = sp - 8'd1;
        addr_n = {STACK_PAGE, sp};
        wdata_n = pc_q[7:0];
        pushed_n = 1'b1;
      end
      PUSH_PCL: if (done) begin
        state_n = PUSH_PSR;
        sp_n = sp - 8'd1;
        addr_n = {STACK_PAGE, sp};
        wdata_n = psr_push;
        pushed_n = 1'b1;
      end
      PUSH_PSR: if (done) begin
        state_n = VEC_L;
        we_n = 1'b0;
        addr_n = vector_of(src);
        pushed_n = 1'b1;
        set_b_n = src == SRC_BRK;
      end
      // entered with req low only after rst, which starts the reset fetch
      VEC_L: if (done) begin
        state_n = VEC_H;
        addr_n = vector_of(src) + 16'd1;
        set_pcl_n = 1'b1;
        rf_data_n = mm2il_data;
      end else if (!il2mm_req) begin
        req_n = 1'b1;
        we_n = 1'b0;
        addr_n = vector_of(src);
      end
      VEC_H: if (done) begin
        state_n = IDLE;
        req_n = 1'b0;
        we_n = 1'b0;
        set_pch_n = 1'b1;
        rf_data_n = mm2il_data;
      end
      default: state_n = IDLE;
    endcase
    busy_n = state_n != IDLE | set_pch_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= VEC_L;
      src <= SRC_RESET;
      pc_q <= '0;
      psr_q <= '0;
      sp <= '0;
      nmi_prev <= 1'b0;
      nmi_pend <= 1'b0;
      il2mm_req <= 1'b0;
      il2mm_we <= 1'b0;
      il2mm_addr <= '0;
      il2mm_data <= '0;
      il2rf_data <= '0;
      il2rf_set_pcl <= 1'b0;
      il2rf_set_pch <= 1'b0;
      il2rf_pushed <= 1'b0;
      il2rf_set_i <= 1'b0;
      il2rf_set_b <= 1'b0;
      il2mc_busy <= 1'b1;
    end else begin
      state <= state_n;
      src <= src_n;
      pc_q <= pc_n;
      psr_q <= psr_n;
      sp <= sp_n;
      nmi_prev <= nmi;
      nmi_pend <= nmi_pend_n;
      il2mm_req <= req_n;
      il2mm_we <= we_n;
      il2mm_addr <= addr_n;
      il2mm_data <= wdata_n;
      il2rf_data <= rf_data_n;
      il2rf_set_pcl <= set_pcl_n;
      il2rf_set_pch <= set_pch_n;
      il2rf_pushed <= pushed_n;
      il2rf_set_i <= set_pch_n;
      il2rf_set_b <= set_b_n;
      il2mc_busy <= busy_n;
    end
  end
endmodule

// File: tb/tb_mc6502_interrupt_sequencer.sv
// tb_mc6502_interrupt_sequencer: transaction-queue model check with directed and random stimulus
module tb_mc6502_interrupt_sequencer;
  logic clk = 1'b0, rst = 1'b1, irq = 1'b0, nmi = 1'b0, mc2il_brk = 1'b0, mc2il_idle = 1'b0;
  logic [15:0] rf2il_pc = '0;
  logic [7:0] rf2il_s = '0, rf2il_psr = '0, mm2il_data = '0;
  logic rf2il_i = 1'b0, mm2il_ack = 1'b0;
  logic il2mm_req, il2mm_we, il2rf_set_pcl, il2rf_set_pch, il2rf_pushed, il2rf_set_i, il2rf_set_b, il2mc_busy;
  logic [15:0] il2mm_addr;
  logic [7:0] il2mm_data, il2rf_data;
  always #5 clk = ~clk;
  mc6502_interrupt_sequencer dut (
    .clk(clk), .rst(rst), .irq(irq), .nmi(nmi), .mc2il_brk(mc2il_brk), .mc2il_idle(mc2il_idle),
    .rf2il_pc(rf2il_pc), .rf2il_s(rf2il_s), .rf2il_psr(rf2il_psr), .rf2il_i(rf2il_i),
    .il2mm_req(il2mm_req), .il2mm_we(il2mm_we), .il2mm_addr(il2mm_addr), .il2mm_data(il2mm_data),
    .mm2il_ack(mm2il_ack), .mm2il_data(mm2il_data), .il2rf_data(il2rf_data),
    .il2rf_set_pcl(il2rf_set_pcl), .il2rf_set_pch(il2rf_set_pch), .il2rf_pushed(il2rf_pushed),
    .il2rf_set_i(il2rf_set_i), .il2rf_set_b(il2rf_set_b), .il2mc_busy(il2mc_busy)
  );
  // kind: 0 = PC byte push, 1 = PSR push, 2 = vector low read, 3 = vector high read
  typedef struct {logic we; logic [15:0] addr; logic [7:0] d; int kind;} acc_t;
  acc_t q[$];
  acc_t obs[$];
  logic [7:0] rfd_log[$];
  logic [7:0] mem [0:65535];
  int checks = 0, errors = 0, ack_pct = 100;
  int pushed_cnt = 0, setb_cnt = 0, busy_cnt = 0;
  bit m_req, m_start, m_busy, m_pushed, m_setb, m_pcl, m_pch, m_brk, pend, prev;
  logic [7:0] m_rfd;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_acc(string n, int i, logic we, logic [15:0] a, logic [7:0] d, bit cd);
    if (i >= obs.size()) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d accesses expected access %0d", n, obs.size(), i);
    end else begin
      chk({n, "_we"}, obs[i].we, we);
      chk({n, "_addr"}, obs[i].addr, a);
      if (cd) chk({n, "_data"}, obs[i].d, d);
    end
  endtask
  task automatic model_step();
    acc_t a;
    bit acc_nmi;
    logic [15:0] v;
    logic [7:0] p;
    acc_nmi = 0;
    if (rst) begin
      q.delete();
      q.push_back('{1'b0, 16'hFFFC, 8'h00, 2});
      q.push_back('{1'b0, 16'hFFFD, 8'h00, 3});
      {m_req, m_pushed, m_setb, m_pcl, m_pch, m_brk, pend, prev} = '0;
      m_start = 1;
      m_busy = 1;
      return;
    end
    {m_pushed, m_setb, m_pcl, m_pch} = '0;
    if (m_req && mm2il_ack) begin
      a = q.pop_front();
      m_pushed = a.kind < 2;
      m_setb = a.kind == 1 && m_brk;
      m_pcl = a.kind == 2;
      m_pch = a.kind == 3;
      if (a.kind >= 2) m_rfd = mm2il_data;
      m_req = q.size() != 0;
    end else if (m_start) begin
      m_req = 1;
      m_start = 0;
    end else if (!m_req && q.size() == 0 && mc2il_idle && (pend || mc2il_brk || (irq && !rf2il_i))) begin
      acc_nmi = pend;
      m_brk = !pend && mc2il_brk;
      v = pend ? 16'hFFFA : 16'hFFFE;
      p = (rf2il_psr & 8'hEF) | 8'h20 | (m_brk ? 8'h10 : 8'h00);
      q.push_back('{1'b1, {8'h01, rf2il_s}, rf2il_pc[15:8], 0});
      q.push_back('{1'b1, {8'h01, 8'(rf2il_s - 8'd1)}, rf2il_pc[7:0], 0});
      q.push_back('{1'b1, {8'h01, 8'(rf2il_s - 8'd2)}, p, 1});
      q.push_back('{1'b0, v, 8'h00, 2});
      q.push_back('{1'b0, v + 16'd1, 8'h00, 3});
      m_req = 1;
    end
    m_busy = q.size() != 0 || m_pch;
    pend = (nmi && !prev) || (pend && !acc_nmi);
    prev = nmi;
  endtask
  task automatic tick();
    mm2il_ack = (il2mm_req === 1'b1) && ($urandom_range(99) < ack_pct);
    mm2il_data = 8'($urandom);
    if (mm2il_ack) begin
      if (il2mm_we) mem[il2mm_addr] = il2mm_data;
      else mm2il_data = mem[il2mm_addr];
      obs.push_back('{il2mm_we, il2mm_addr, il2mm_we ? il2mm_data : mem[il2mm_addr], 0});
    end
    model_step();
    @(negedge clk);
    chk("req", il2mm_req, m_req);
    chk("busy", il2mc_busy, m_busy);
    chk("pushed", il2rf_pushed, m_pushed);
    chk("set_b", il2rf_set_b, m_setb);
    chk("set_pcl", il2rf_set_pcl, m_pcl);
    chk("set_pch", il2rf_set_pch, m_pch);
    chk("set_i", il2rf_set_i, m_pch);
    if (m_req && q.size() > 0) begin
      chk("we", il2mm_we, q[0].we);
      chk("addr", il2mm_addr, q[0].addr);
      if (q[0].we) chk("wdata", il2mm_data, q[0].d);
    end
    if (m_pcl || m_pch) chk("rf_data", il2rf_data, m_rfd);
    if (il2rf_set_pcl || il2rf_set_pch) rfd_log.push_back(il2rf_data);
    pushed_cnt += int'(il2rf_pushed);
    setb_cnt += int'(il2rf_set_b);
    busy_cnt += int'(il2mc_busy);
  endtask
  task automatic run(int n);
    for (int k = 0; k < n; k++) tick();
  endtask
  task automatic clear_logs();
    obs.delete();
    rfd_log.delete();
    pushed_cnt = 0;
    setb_cnt = 0;
    busy_cnt = 0;
  endtask
  initial begin
    mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'hE0;
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'hC0;
    mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'hD0;
    tick();
    chk("reset_req", il2mm_req, 1'b0);
    chk("reset_busy", il2mc_busy, 1'b1);
    chk("reset_pch", il2rf_set_pch, 1'b0);
    tick();
    clear_logs();
    rst = 0;
    run(8);
    chk("rv_count", obs.size(), 2);
    chk_acc("rv0", 0, 1'b0, 16'hFFFC, 8'h00, 1);
    chk_acc("rv1", 1, 1'b0, 16'hFFFD, 8'hC0, 1);
    chk("rv_rfd_n", rfd_log.size(), 2);
    if (rfd_log.size() == 2) begin
      chk("rv_pcl_data", rfd_log[0], 8'h00);
      chk("rv_pch_data", rfd_log[1], 8'hC0);
    end
    chk("rv_idle_busy", il2mc_busy, 1'b0);
    clear_logs();
    rf2il_pc = 16'h1234; rf2il_s = 8'hFD; rf2il_psr = 8'hA1; rf2il_i = 0; mc2il_idle = 1; irq = 1;
    tick();
    irq = 0;
    run(14);
    chk("irq_count", obs.size(), 5);
    chk_acc("irq0", 0, 1'b1, 16'h01FD, 8'h12, 1);
    chk_acc("irq1", 1, 1'b1, 16'h01FC, 8'h34, 1);
    chk_acc("irq2", 2, 1'b1, 16'h01FB, 8'hA1, 1);
    chk_acc("irq3", 3, 1'b0, 16'hFFFE, 8'h00, 0);
    chk_acc("irq4", 4, 1'b0, 16'hFFFF, 8'h00, 0);
    chk("irq_pushed", pushed_cnt, 3);
    chk("irq_setb", setb_cnt, 0);
    clear_logs();
    rf2il_psr = 8'h00; irq = 1; mc2il_brk = 1;
    tick();
    mc2il_brk = 0; irq = 0;
    run(14);
    chk_acc("brk_psr", 2, 1'b1, 16'h01FB, 8'h30, 1);
    chk_acc("brk_vec", 3, 1'b0, 16'hFFFE, 8'h00, 0);
    chk("brk_setb", setb_cnt, 1);
    clear_logs();
    rf2il_i = 1; irq = 1;
    run(20);
    chk("mask_count", obs.size(), 0);
    chk("mask_busy", busy_cnt, 0);
    rf2il_i = 0;
    tick();
    irq = 0;
    run(3);
    nmi = 1;
    run(30);
    nmi = 0;
    chk("nest_count", obs.size(), 10);
    chk_acc("nest_irq", 3, 1'b0, 16'hFFFE, 8'h00, 0);
    chk_acc("nest_nmi", 8, 1'b0, 16'hFFFA, 8'h00, 0);
    run(2);
    clear_logs();
    rf2il_s = 8'h01;
    nmi = 1;
    run(16);
    nmi = 0;
    chk_acc("wrap0", 0, 1'b1, 16'h0101, 8'h12, 1);
    chk_acc("wrap1", 1, 1'b1, 16'h0100, 8'h34, 1);
    chk_acc("wrap2", 2, 1'b1, 16'h01FF, 8'h20, 1);
    chk_acc("wrap_vec", 3, 1'b0, 16'hFFFA, 8'h00, 0);
    run(2);
    clear_logs();
    rf2il_s = 8'hFD; irq = 1;
    tick();
    irq = 0;
    tick();
    ack_pct = 0;
    nmi = 1;
    tick();
    nmi = 0;
    run(2);
    rst = 1;
    tick();
    rst = 0;
    ack_pct = 100;
    obs.delete();
    run(25);
    chk("rmid_count", obs.size(), 2);
    chk_acc("rmid0", 0, 1'b0, 16'hFFFC, 8'h00, 1);
    chk_acc("rmid1", 1, 1'b0, 16'hFFFD, 8'hC0, 1);
    for (int a = 16'hFFFA; a <= 16'hFFFF; a++) mem[a] = 8'($urandom);
    ack_pct = 60;
    for (int k = 0; k < 4000; k++) begin
      rst = $urandom_range(999) < 3;
      if ($urandom_range(9) == 0) irq = ~irq;
      if ($urandom_range(14) == 0) nmi = ~nmi;
      mc2il_brk = $urandom_range(19) == 0;
      mc2il_idle = $urandom_range(9) < 7;
      rf2il_i = $urandom_range(3) == 0;
      rf2il_pc = 16'($urandom);
      rf2il_s = 8'($urandom);
      rf2il_psr = 8'($urandom);
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
